// File: rtl/mult_div_unit_pkg.sv
// Shared constants and helpers for the HI/LO multiply/divide unit.
// Op codes, FSM state encodings and op-decoding helpers live here.
package mult_div_unit_pkg;

    localparam int MDU_N = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/control bundle between the register-file stage and the MDU.
// master = pipeline side, slave = multiply/divide unit.
interface mult_div_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         hi_wen;
    logic         lo_wen;
    logic [N-1:0] wd;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, inA, inB, hi_wen, lo_wen, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, hi_wen, lo_wen, wd,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for sign-correcting the final product/quotient/remainder.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI and LO.
// Shift-add multiply and restoring divide, N+1 cycles per operation.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic              clock,
    input  logic              reset,
    mult_div_unit_if.slave    bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mdu_state_e     r_state;
    mdu_op_e        r_op;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_m;
    logic [2*N-1:0] r_acc;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic           r_busy;
    logic           r_done;

    logic           w_sa;
    logic           w_sb;
    logic           w_b_zero;
    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_mul_next;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_div_next;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;
    logic [N-1:0]   w_res_hi;
    logic [N-1:0]   w_res_lo;

    assign w_sa     = op_is_signed(bus.op) & bus.inA[N-1];
    assign w_sb     = op_is_signed(bus.op) & bus.inB[N-1];
    assign w_b_zero = (bus.inB == '0);

    mdu_sign_fix #(.W(N)) u_mag_a (
        .i_val (bus.inA),
        .i_neg (w_sa),
        .o_val (w_mag_a)
    );

    mdu_sign_fix #(.W(N)) u_mag_b (
        .i_val (bus.inB),
        .i_neg (w_sb),
        .o_val (w_mag_b)
    );

    // Multiply: multiplier sits in the low half and is consumed LSB first.
    assign w_sum = {1'b0, r_acc[2*N-1:N]}
                 + (r_acc[0] ? {1'b0, r_m} : {(N+1){1'b0}});
    assign w_mul_next = {w_sum, r_acc[N-1:1]};

    // Divide: {remainder, dividend/quotient} shifted left one bit per step.
    assign w_diff = r_acc[2*N-1:N-1] - {1'b0, r_m};
    assign w_div_next = w_diff[N]
                      ? {r_acc[2*N-2:0], 1'b0}
                      : {w_diff[N-1:0], r_acc[N-2:0], 1'b1};

    mdu_sign_fix #(.W(2*N)) u_fix_p (
        .i_val (r_acc),
        .i_neg (r_neg_q),
        .o_val (w_prod)
    );

    mdu_sign_fix #(.W(N)) u_fix_q (
        .i_val (r_acc[N-1:0]),
        .i_neg (r_neg_q),
        .o_val (w_quo)
    );

    mdu_sign_fix #(.W(N)) u_fix_r (
        .i_val (r_acc[2*N-1:N]),
        .i_neg (r_neg_r),
        .o_val (w_rem)
    );

    assign w_res_hi = op_is_div(r_op) ? w_rem : w_prod[2*N-1:N];
    assign w_res_lo = op_is_div(r_op) ? w_quo : w_prod[N-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= MDU_MULT;
            r_cnt   <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= mdu_op_e'(bus.op);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                        if (op_is_div(bus.op)) begin
                            r_m   <= w_mag_b;
                            r_acc <= {{N{1'b0}}, w_mag_a};
                        end else begin
                            r_m   <= w_mag_a;
                            r_acc <= {{N{1'b0}}, w_mag_b};
                        end
                        // Divide by zero keeps the raw all-ones quotient.
                        r_neg_q <= (w_sa ^ w_sb)
                                 & ~(op_is_div(bus.op) & w_b_zero);
                        r_neg_r <= op_is_div(bus.op) & w_sa;
                    end else begin
                        if (bus.hi_wen) r_hi <= bus.wd;
                        if (bus.lo_wen) r_lo <= bus.wd;
                    end
                end
                S_CALC: begin
                    r_acc <= op_is_div(r_op) ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a
// plain-arithmetic reference of the MIPS HI/LO semantics.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int N = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mult_div_unit_if #(.N(N)) bus ();

    mult_div_unit #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {(a % b), (a / b)};
            end
        endcase
    endfunction

    // Launch one op; if ign_at > 0, a competing start plus HI/LO
    // writes is driven so it is sampled at edge E<ign_at>.
    task automatic do_op(input string tag,
                         input logic [1:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int ign_at);
        logic [63:0] exp;
        int n;
        bit seen;
        bit busy_ok;
        exp = model(op, a, b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.inA   = a;
        bus.inB   = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.inA   = $urandom;
        bus.inB   = $urandom;
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 100) begin
            if (ign_at > 0 && n + 1 == ign_at) begin
                bus.start  = 1'b1;
                bus.op     = MDU_DIVU;
                bus.inA    = 32'd9;
                bus.inB    = 32'd3;
                bus.hi_wen = 1'b1;
                bus.lo_wen = 1'b1;
                bus.wd     = 32'hDEAD_BEEF;
            end
            @(posedge clock);
            #1;
            n++;
            bus.start  = 1'b0;
            bus.hi_wen = 1'b0;
            bus.lo_wen = 1'b0;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] edge_v [6];
        bit any_done;

        edge_v[0] = 32'h0;
        edge_v[1] = 32'h1;
        edge_v[2] = 32'hFFFF_FFFF;
        edge_v[3] = 32'h8000_0000;
        edge_v[4] = 32'h7FFF_FFFF;
        edge_v[5] = 32'h0000_0007;

        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.inA    = '0;
        bus.inB    = '0;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        bus.wd     = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        do_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 0);
        do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_z", MDU_DIVU, 32'd100, 32'd0, 0);
        do_op("div_z", MDU_DIV, 32'hFFFF_FF00, 32'd0, 0);
        do_op("ignore", MDU_MULTU, 32'd5, 32'd6, 5);

        // Reset mid-divide discards everything.
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = MDU_DIVU;
        bus.inA   = 32'd1000;
        bus.inB   = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_hi", 64'(bus.hi), 64'd0);
        chk("mid_rst_lo", 64'(bus.lo), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) any_done = 1'b1;
        end
        chk("mid_rst_nodone", 64'(any_done), 64'd0);

        // MTLO / MTHI
        @(negedge clock);
        bus.lo_wen = 1'b1;
        bus.wd     = 32'h0000_1234;
        @(posedge clock);
        #1;
        bus.lo_wen = 1'b0;
        chk("mtlo", 64'(bus.lo), 64'h1234);
        chk("mtlo_hi", 64'(bus.hi), 64'd0);
        @(negedge clock);
        bus.hi_wen = 1'b1;
        bus.lo_wen = 1'b1;
        bus.wd     = 32'hCAFE_0001;
        @(posedge clock);
        #1;
        bus.hi_wen = 1'b0;
        bus.lo_wen = 1'b0;
        chk("mthilo_hi", 64'(bus.hi), 64'hCAFE_0001);
        chk("mthilo_lo", 64'(bus.lo), 64'hCAFE_0001);

        // start together with MTHI: the write is dropped.
        @(negedge clock);
        bus.start  = 1'b1;
        bus.op     = MDU_MULTU;
        bus.inA    = 32'd3;
        bus.inB    = 32'd4;
        bus.hi_wen = 1'b1;
        bus.wd     = 32'h5555_AAAA;
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.hi_wen = 1'b0;
        chk("st_wen_hi", 64'(bus.hi), 64'hCAFE_0001);
        chk("st_wen_busy", 64'(bus.busy), 64'd1);
        repeat (33) @(posedge clock);
        #1;
        chk("st_wen_done", 64'(bus.done), 64'd1);
        chk("st_wen_res", {32'(bus.hi), 32'(bus.lo)}, 64'd12);

        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)]
                                              : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)]
                                              : $urandom;
            if (i % 5 == 0) rb = rb >> $urandom_range(0, 31);
            do_op("rand", 2'(i % 4), ra, rb, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
